// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM stage and its memory handshake FSM.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit positions inside the 2-bit WB control bundle.
  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  localparam int TIMEOUT_CYCLES_DEF = 255;
  localparam int CNT_W_DEF          = 8;

  // Request side of the memory handshake, held stable for the whole access.
  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Memory is word addressed: byte offset bits are always presented as 0.
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory handshake: issues one registered request per load/store, holds it
// until ack, buffers the read data and stalls upstream while busy.
// Optional abort on a stuck memory: define MEM_TIMEOUT_EN.
module mem_access_fsm
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        ack_i,
  input  logic [31:0] rdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rbuf_o,
  output logic        err_o
);

  state_e      state_q, state_d;
  mem_req_t    req_q, req_d;
  logic [31:0] rbuf_q, rbuf_d;

  // A counter too narrow to reach the timeout value is a configuration bug.
  if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_cnt_w_too_narrow
  end

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Next-state, request and buffer update; stall/done decoded from state.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rbuf_d  = rbuf_q;
    stall_o = 1'b0;
    done_o  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rd_i || wr_i) begin
          stall_o     = 1'b1;
          req_d.req   = 1'b1;
          req_d.we    = wr_i;  // store wins when both are asserted
          req_d.addr  = word_addr(addr_i);
          req_d.wdata = wdata_i;
          state_d     = WAIT;
`ifdef MEM_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (ack_i) begin
          rbuf_d    = req_q.we ? 32'h0 : rdata_i;
          req_d.req = 1'b0;
          state_d   = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Give up: release the bus and retire the instruction with zero data.
          rbuf_d    = 32'h0;
          req_d.req = 1'b0;
          err_d     = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        // Instruction retires into MEM/WB this edge; going straight to IDLE
        // keeps the same instruction from re-issuing.
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request and read-buffer registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      rbuf_q  <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rbuf_q  <= rbuf_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign mem_req_o   = req_q.req;
  assign mem_we_o    = req_q.we;
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;
  assign rbuf_o      = rbuf_q;

`ifdef MEM_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register. Loads/stores go through
// mem_access_fsm; while it stalls, bubbles enter MEM/WB so nothing is written
// back twice. Optional memory timeout: define MEM_TIMEOUT_EN.
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  WB_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [4:0]  RDaddr_i,
  input  logic [31:0] ALUdata_i,
  input  logic [31:0] data_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic [1:0]  WB_o,
  output logic        FW_o,
  output logic [4:0]  RDaddr_o,
  output logic [31:0] MEMdata_o,
  output logic [31:0] ALUdata_o,
  output logic [31:0] WBdata_o,
  output logic        err_o
);

  logic        stall, done;
  logic [31:0] rbuf;

  logic [1:0]  wb_q, wb_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] memdata_q, memdata_d;
  logic [31:0] aludata_q, aludata_d;

  mem_access_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_fsm (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .rd_i        (MemRead_i),
    .wr_i        (MemWrite_i),
    .addr_i      (ALUdata_i),
    .wdata_i     (data_i),
    .ack_i       (mem_ack_i),
    .rdata_i     (mem_rdata_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .stall_o     (stall),
    .done_o      (done),
    .rbuf_o      (rbuf),
    .err_o       (err_o)
  );

  // MEM/WB load: bubble while stalled (data regs keep their value), else
  // capture EX/MEM with load data from the buffer only on a retiring access.
  always_comb begin
    wb_d      = wb_q;
    rd_d      = rd_q;
    memdata_d = memdata_q;
    aludata_d = aludata_q;
    if (stall) begin
      wb_d = 2'b00;
      rd_d = 5'd0;
    end else begin
      wb_d      = WB_i;
      rd_d      = RDaddr_i;
      aludata_d = ALUdata_i;
      memdata_d = done ? rbuf : 32'h0;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_q      <= '0;
      rd_q      <= '0;
      memdata_q <= '0;
      aludata_q <= '0;
    end else begin
      wb_q      <= wb_d;
      rd_q      <= rd_d;
      memdata_q <= memdata_d;
      aludata_q <= aludata_d;
    end
  end

  assign stall_o   = stall;
  assign WB_o      = wb_q;
  assign FW_o      = wb_q[WB_REGWRITE];
  assign RDaddr_o  = rd_q;
  assign MEMdata_o = memdata_q;
  assign ALUdata_o = aludata_q;
  assign WBdata_o  = wb_q[WB_MEMTOREG] ? memdata_q : aludata_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM stage plus MEM/WB pipeline register; sits directly downstream of the EX/MEM register and consumes its WB, MemRead/MemWrite, RDaddr, ALU result and store-data outputs.
- Performs data-memory accesses over a req/ack handshake to a variable-latency memory.
- Drives stall_o back to EX/MEM (its stall_i) and earlier stages while an access is outstanding.
- Presents registered write-back controls, data and forwarding info to WB and the forwarding unit.

Parameters:
- TIMEOUT_CYCLES, 255, max WAIT cycles before abort (used only with MEM_TIMEOUT_EN).
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- WB_i  in  2  [0]=RegWrite, [1]=MemtoReg from EX/MEM.
- MemRead_i  in  1  load request.
- MemWrite_i  in  1  store request.
- RDaddr_i  in  5  destination register.
- ALUdata_i  in  32  ALU result / memory address.
- data_i  in  32  store data.
- mem_req_o  out  1  memory request, registered.
- mem_we_o  out  1  1=write, 0=read; valid with req.
- mem_addr_o  out  32  word address; bits[1:0] forced 0.
- mem_wdata_o  out  32  store data.
- mem_ack_i  in  1  one-cycle completion pulse.
- mem_rdata_i  in  32  read data; valid with ack.
- stall_o  out  1  freeze upstream stages.
- WB_o  out  2  registered WB controls.
- FW_o  out  1  WB_o[0], for forwarding.
- RDaddr_o  out  5  registered destination.
- MEMdata_o  out  32  registered load data.
- ALUdata_o  out  32  registered ALU result.
- WBdata_o  out  32  WB_o[1] ? MEMdata_o : ALUdata_o (combinational).
- err_o  out  1  sticky timeout flag; constant 0 without MEM_TIMEOUT_EN.

Behaviour:
- Reset (async, immediate): state=IDLE. mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o = 0. WB_o, RDaddr_o, MEMdata_o, ALUdata_o = 0. Wait counter = 0. err_o = 0. Reset mid-access drops mem_req_o at once; any later ack is ignored.
- FSM states: IDLE, WAIT, DONE.
- IDLE, no MemRead_i/MemWrite_i:
  - stall_o=0.
  - MEM/WB captures inputs on the next edge; latency 1 cycle.
  - MEMdata_o captures 0.
- IDLE with an access:
  - stall_o=1 combinationally.
  - Next edge: latch mem_addr/wdata/we, set mem_req_o=1, go to WAIT.
  - MemWrite_i has priority if both are asserted, i.e. it is treated as a store.
- WAIT:
  - stall_o=1; req/addr/we/wdata held stable.
  - On mem_ack_i: capture mem_rdata_i into an internal buffer (0 for stores), drop mem_req_o on that edge, go to DONE.
  - Ack arriving in the same cycle req rises (the first WAIT cycle) is legal.
- DONE:
  - stall_o=0.
  - MEM/WB captures EX/MEM inputs with MEMdata_o taken from the buffer; return to IDLE on the same edge. This prevents re-triggering on the same instruction.
  - Load/store latency = 2 + N cycles, where N = WAIT cycles up to and including ack.
- Bubble rule: while stall_o=1, each edge loads a bubble into MEM/WB (WB_o=0, RDaddr_o=0, data regs unchanged). No duplicate write-back.
- mem_ack_i outside WAIT is ignored.
- Back-to-back accesses: after DONE, IDLE sees the next instruction and re-stalls; there is no idle cycle on mem_req_o beyond the IDLE decision cycle.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Enabled:
  - The wait counter increments each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYCLES, the request is aborted: req drops, DONE is entered with buffer=0, and err_o is set (sticky until reset).
  - The counter clears on entry to WAIT.
- Disabled:
  - No counter; WAIT persists until ack; err_o tied to 0.

Decomposition:
- Package mem_pkg:
  - state enum {IDLE, WAIT, DONE}.
  - WB bit index constants WB_REGWRITE=0, WB_MEMTOREG=1.
  - Default TIMEOUT_CYCLES.
- Sub-module mem_access_fsm:
  - Contains the handshake FSM, wait counter, request registers and read buffer.
  - Outputs stall and done.
- mem_wb_stage contains the MEM/WB register and the WBdata mux.

Test Plan:
- ALU op WB_i=2'b01, RDaddr_i=5, ALUdata_i=0x1234, no mem → next edge WB_o=01, RDaddr_o=5, WBdata_o=0x1234; stall_o never asserted.
- Load addr 0x103, ack after 3 WAIT cycles with rdata 0xDEADBEEF:
  - mem_addr_o=0x100, mem_we_o=0.
  - stall_o high 4 cycles; bubbles (WB_o=0) meanwhile.
  - Then WB_o=11, WBdata_o=0xDEADBEEF; exactly one ack consumed.
- Store data 0xCAFEF00D addr 0x40, ack in first WAIT cycle → mem_we_o=1, mem_wdata_o=0xCAFEF00D, total 3-cycle occupancy, MEMdata_o=0.
- Assert rst_n_i low while in WAIT → mem_req_o, stall_o, WB_o immediately 0; a later ack has no effect; a following ALU op passes normally.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → req drops after 4 WAIT cycles, err_o=1 and stays 1, WBdata_o=0 for the load.
- Two consecutive loads, each acked after 1 cycle, plus a spurious ack in IDLE → both complete in order with correct data; the spurious ack is ignored.
